// File: rtl/nand_bus_pkg.sv
// nand_bus_pkg
// Shared types and constants for the NAND bus arbiter slice.
//   bus_state_t : arbiter states (IDLE, OWN, GAP)
//   *_BIT       : position of each control line inside a 5-bit phase vector,
//                 ordered nCE|CLE|ALE|nRE|nWE from MSB to LSB
//   PARK_VEC    : idle bus level (chip deselected, both strobes high)
//   phase_vec() : builds a phase vector from individual line levels
//   idx_width() : index width for a given requester count (minimum 1)
package nand_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } bus_state_t;

  localparam int NCE_BIT = 4;
  localparam int CLE_BIT = 3;
  localparam int ALE_BIT = 2;
  localparam int NRE_BIT = 1;
  localparam int NWE_BIT = 0;

  function automatic logic [4:0] phase_vec(input logic nce, input logic cle,
                                           input logic ale, input logic nre,
                                           input logic nwe);
    logic [4:0] v;
    v = '0;
    v[NCE_BIT] = nce;
    v[CLE_BIT] = cle;
    v[ALE_BIT] = ale;
    v[NRE_BIT] = nre;
    v[NWE_BIT] = nwe;
    return v;
  endfunction

  // Parked bus: nCE, nRE and nWE high; CLE and ALE low (5'b10011).
  localparam logic [4:0] PARK_VEC = phase_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nand_bus_arbiter_rr.sv
// rr_arbiter
// Combinational rotate-priority picker.  The search starts one position
// after last_idx and wraps, so the previous owner is always considered last.
// Ports:
//   req      : request vector
//   last_idx : index of the most recent owner
//   pick     : one-hot winner (all zero when nothing requests)
//   pick_idx : binary index of the winner
//   valid    : at least one request present
module rr_arbiter
  import nand_bus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               valid
);

  // Walk the requesters in rotated order and keep the first one found.
  always_comb begin
    int cand;
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    cand     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_idx) + i) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid      = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/nand_bus_arbiter.sv
// nand_bus_arbiter
// Shares one NAND toggle/phase engine among NUM_REQ operation engines.
// A round-robin pick grants exclusive ownership; the owner's phase request is
// forwarded to the engine and the engine's done is routed back to the owner
// only.  Ownership ends on release (deferred until an in-flight phase ends) or
// on watchdog expiry, followed by TURN_CYC parked cycles before re-arbitration.
// The per-engine give-up pulse is named req_release because "release" is a
// reserved word in SystemVerilog.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   req                   : level request per engine
//   req_release           : 1-cycle give-up pulse per engine
//   req_tog_en            : per-engine phase start pulse
//   req_setup / req_hold  : per-engine 5-bit phase vectors
//   req_cnt / req_dout    : per-engine repeat count and write byte
//   tog_done              : phase engine done pulse
//   nand_rb_n             : NAND ready/busy (1 = ready)
//   grant                 : one-hot ownership
//   done_out              : tog_done routed to the owner
//   tog_en .. tog_cnt     : phase engine controls
//   nand_dout             : NAND IO write byte
//   owner_idx             : current or last owner
//   timeout_err           : 1-cycle pulse on forced revoke
module nand_bus_arbiter
  import nand_bus_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 4096,
  parameter  int TURN_CYC    = 2,
  parameter  int CNT_W       = 12,
  localparam int IDX_W       = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_release,
  input  logic [NUM_REQ-1:0]       req_tog_en,
  input  logic [NUM_REQ*5-1:0]     req_setup,
  input  logic [NUM_REQ*5-1:0]     req_hold,
  input  logic [NUM_REQ*CNT_W-1:0] req_cnt,
  input  logic [NUM_REQ*8-1:0]     req_dout,
  input  logic                     tog_done,
  input  logic                     nand_rb_n,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done_out,
  output logic                     tog_en,
  output logic [4:0]               tog_setup,
  output logic [4:0]               tog_hold,
  output logic [CNT_W-1:0]         tog_cnt,
  output logic [7:0]               nand_dout,
  output logic [IDX_W-1:0]         owner_idx,
  output logic                     timeout_err
);

  localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam int GAP_W = $clog2(TURN_CYC + 1) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

  bus_state_t         state;
  logic               busy;
  logic               pending_release;
  logic [WD_W-1:0]    wdog;
  logic [GAP_W-1:0]   gap_cnt;

  logic [NUM_REQ-1:0] arb_pick;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  logic               own_tog_en;
  logic               own_release;
  logic [4:0]         own_setup;
  logic [4:0]         own_hold;
  logic [CNT_W-1:0]   own_cnt;
  logic [7:0]         own_dout;

  logic               busy_after;
  logic               rel_now;
  logic               wd_expired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req      (req),
    .last_idx (owner_idx),
    .pick     (arb_pick),
    .pick_idx (arb_idx),
    .valid    (arb_valid)
  );

  // Select the current owner's slice of every per-engine input.
  always_comb begin
    own_tog_en  = 1'b0;
    own_release = 1'b0;
    own_setup   = PARK_VEC;
    own_hold    = PARK_VEC;
    own_cnt     = '0;
    own_dout    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_idx == IDX_W'(i)) begin
        own_tog_en  = req_tog_en[i];
        own_release = req_release[i];
        own_setup   = req_setup[i*5 +: 5];
        own_hold    = req_hold[i*5 +: 5];
        own_cnt     = req_cnt[i*CNT_W +: CNT_W];
        own_dout    = req_dout[i*8 +: 8];
      end
    end
  end

  // busy_after is the phase-in-flight flag as it will be after this cycle; a
  // new start wins over a coincident done.  A release (fresh or pending) may
  // only end ownership once no phase is in flight.
  assign busy_after = own_tog_en | (busy & ~tog_done);
  assign rel_now    = own_release | pending_release;
  assign wd_expired = (wdog == WD_LIMIT);

  // Main state machine; every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      grant           <= '0;
      done_out        <= '0;
      tog_en          <= 1'b0;
      tog_setup       <= PARK_VEC;
      tog_hold        <= PARK_VEC;
      tog_cnt         <= '0;
      nand_dout       <= '0;
      owner_idx       <= IDX_W'(NUM_REQ - 1);
      timeout_err     <= 1'b0;
      busy            <= 1'b0;
      pending_release <= 1'b0;
      wdog            <= '0;
      gap_cnt         <= '0;
    end else begin
      tog_en      <= 1'b0;
      done_out    <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid && nand_rb_n) begin
            grant           <= arb_pick;
            owner_idx       <= arb_idx;
            wdog            <= '0;
            pending_release <= 1'b0;
            state           <= OWN;
          end
        end

        OWN: begin
          wdog <= wdog + 1'b1;
          if (tog_done) begin
            done_out <= grant;
          end
          if (rel_now && !busy_after) begin
            grant           <= '0;
            pending_release <= 1'b0;
            busy            <= 1'b0;
            gap_cnt         <= '0;
            tog_setup       <= PARK_VEC;
            tog_hold        <= PARK_VEC;
            tog_cnt         <= '0;
            nand_dout       <= '0;
            state           <= GAP;
          end else if (wd_expired) begin
            // A release already pending counts as a release, not an error.
            // Any phase still running is drained in GAP.
            grant           <= '0;
            timeout_err     <= ~rel_now;
            pending_release <= 1'b0;
            busy            <= busy & ~tog_done;
            gap_cnt         <= '0;
            tog_setup       <= PARK_VEC;
            tog_hold        <= PARK_VEC;
            tog_cnt         <= '0;
            nand_dout       <= '0;
            state           <= GAP;
          end else begin
            busy            <= busy_after;
            pending_release <= rel_now;
            if (own_tog_en) begin
              tog_en    <= 1'b1;
              tog_setup <= own_setup;
              tog_hold  <= own_hold;
              tog_cnt   <= own_cnt;
              nand_dout <= own_dout;
            end
          end
        end

        GAP: begin
          // The phase engine cannot abort, so an in-flight phase is drained
          // first; its done is deliberately not routed to anyone.
          if (busy) begin
            if (tog_done) begin
              busy <= 1'b0;
            end
          end else if (int'(gap_cnt) + 1 >= TURN_CYC) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/nand_bus_arbiter.md
Name: nand_bus_arbiter

Overview:
- Shares the single NAND toggle/phase engine (nCE|CLE|ALE|nRE|nWE waveform generator) among NUM_REQ operation engines: read-ID, page read, program, erase.
- Round-robin grants exclusive bus ownership and muxes the owner's phase configuration to the engine.
- Returns the engine's done only to the owner.
- Enforces turnaround gaps, R/B# gating and an ownership watchdog.

Parameters:
- NUM_REQ, 4, number of requesting operation engines.
- TIMEOUT_CYC, 4096, max cycles one owner may hold the bus before forced revoke.
- TURN_CYC, 2, parked-bus cycles between owners.
- CNT_W, 12, width of the phase repeat count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req  in  NUM_REQ  level request per engine.
- release  in  NUM_REQ  1-cycle pulse; owner gives up the bus.
- req_tog_en  in  NUM_REQ  per-engine phase start pulse.
- req_setup  in  NUM_REQ*5  per-engine setup vector.
- req_hold  in  NUM_REQ*5  per-engine hold vector.
- req_cnt  in  NUM_REQ*CNT_W  per-engine repeat count.
- req_dout  in  NUM_REQ*8  per-engine NAND IO write byte.
- tog_done  in  1  phase engine done pulse.
- nand_rb_n  in  1  NAND ready/busy, 1 = ready.
- grant  out  NUM_REQ  one-hot ownership.
- done_out  out  NUM_REQ  tog_done routed to the owner.
- tog_en  out  1  to phase engine.
- tog_setup  out  5  to phase engine.
- tog_hold  out  5  to phase engine.
- tog_cnt  out  CNT_W  to phase engine.
- nand_dout  out  8  to NAND IO.
- owner_idx  out  log2(NUM_REQ)  current or last owner.
- timeout_err  out  1  1-cycle pulse on forced revoke.

Behaviour:
- Reset values:
  - grant = 0, done_out = 0, tog_en = 0.
  - tog_setup = tog_hold = PARK_VEC (5'b10011: nCE, nRE, nWE high).
  - tog_cnt = 0, nand_dout = 0, timeout_err = 0.
  - owner_idx = NUM_REQ-1, so requester 0 wins first. State = IDLE.
- All outputs are registered. Reset mid-operation immediately parks the bus and clears all state, including busy and the watchdog.
- IDLE:
  - Bus parked.
  - If |req and nand_rb_n == 1, the winner is the first set req searching from owner_idx+1 with wrap.
  - Next cycle: grant[winner] = 1, owner_idx = winner, watchdog = 0, state OWN.
  - Grant latency from req = 1 cycle minimum.
- OWN:
  - tog_en/setup/hold/cnt/dout register the owner's slice (1-cycle latency).
  - done_out[owner] = registered tog_done; other done_out bits stay 0.
  - Non-owner req_tog_en is ignored.
  - busy flag: set when the owner's tog_en is forwarded; cleared on tog_done.
  - release[owner] while not busy: drop grant next cycle, state GAP.
  - release[owner] while busy: latch pending_release; on tog_done, drop grant and go to GAP.
  - release from a non-owner is ignored.
  - req deassertion without release does not end ownership.
- Watchdog:
  - Increments every OWN cycle.
  - At TIMEOUT_CYC-1: grant = 0, timeout_err pulses 1 cycle, state GAP.
  - Release and timeout in the same cycle count as a release; no error is raised.
- GAP:
  - Bus parked, tog_en = 0.
  - If busy, wait for tog_done; the phase engine cannot abort, and that done_out is suppressed.
  - Then TURN_CYC parked cycles, then IDLE.
  - req is not sampled during GAP.
- Fairness: a requester that just released has lowest priority in the next arbitration. No starvation with all req held high.
- While nand_rb_n == 0, IDLE holds and no grant is issued. The current owner is not affected by R/B#.

Decomposition:
- Package nand_bus_pkg:
  - State enum {IDLE, OWN, GAP}.
  - PARK_VEC.
  - Bit-position constants for nCE/CLE/ALE/nRE/nWE.
- Sub-module rr_arbiter: combinational rotate-priority pick from req and last index; outputs one-hot plus index.

Test Plan:
- Reset with req=4'b0001, rb=1 → grant=0001 two cycles after reset release; owner_idx=0; tog_setup=5'b10011 until the owner's first tog_en.
- req=4'b1111 held, each owner issues one phase and then a release → grant order 0,1,2,3,0; TURN_CYC=2 parked cycles between grants.
- Owner 1 sends setup=10010, hold=11010, cnt=1, dout=8'h90 with tog_en; release pulsed before tog_done → values forwarded 1 cycle later; grant held until tog_done; done_out=0010 for one cycle; then GAP.
- Owner never releases, TIMEOUT_CYC=16 → grant drops at cycle 16 after grant; timeout_err one pulse; next requester granted after GAP.
- nand_rb_n=0 with req=0100 → no grant; rb→1 → grant=0100 one cycle later.
- reset asserted mid-phase in OWN → all outputs return to reset values asynchronously; after release, requester 0 has priority.
